// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct encodings, fetch FSM states and reset PC.
package mips_pkg;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_NOOP    = 6'h00;
   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_SYSCALL = 6'h0C;
   localparam logic [5:0] FN_ADD     = 6'h20;
   localparam logic [5:0] FN_SUB     = 6'h22;
   localparam logic [5:0] FN_SLT     = 6'h2A;

   typedef enum logic [2:0] {
      S_RESET,
      S_FETCH,
      S_WAIT,
      S_ISSUE,
      S_EXEC,
      S_HALT
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch_pc_next_sel.sv
// Combinational next-PC selection: JR > J/JAL > taken branch > sequential.
module pc_next_sel
   import mips_pkg::*;
(
   input  logic [31:0] pc_plus4_i,
   input  logic [25:0] target26_i,
   input  logic [15:0] imm16_i,
   input  logic [31:0] jr_target_i,
   input  logic        jump_i,
   input  logic        jump_sel_i,
   input  logic        branch_i,
   input  logic        branch_taken_i,
   output logic [31:0] next_pc_o
);

   logic [31:0] br_off;
   logic [31:0] br_pc;
   logic [31:0] j_pc;

   assign br_off = {{14{imm16_i[15]}}, imm16_i, 2'b00};
   assign br_pc  = pc_plus4_i + br_off;
   assign j_pc   = {pc_plus4_i[31:28], target26_i, 2'b00};

   always_comb begin
      next_pc_o = pc_plus4_i;
      if (jump_i && jump_sel_i) begin
         next_pc_o = {jr_target_i[31:2], 2'b00};
      end else if (jump_i) begin
         next_pc_o = j_pc;
      end else if (branch_i && branch_taken_i) begin
         next_pc_o = br_pc;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Multi-cycle MIPS fetch/sequencing unit: owns the PC, fetches over req/valid, splits fields.
// Optional FETCH_HALT_EN: SYSCALL in ISSUE parks the unit in HALT until reset.
module instr_fetch
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   output logic [5:0]  opcode,
   output logic [5:0]  funct,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [15:0] imm16,
   output logic [25:0] target26,
   output logic [31:0] pc_plus4,
   output logic        instr_valid,
   input  logic        Jump,
   input  logic        Branch,
   input  logic        JumpSel,
   input  logic        branch_taken,
   input  logic [31:0] jr_target,
   output logic        halted
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  ir_q, ir_d;
   logic [31:0]  next_pc;

   pc_next_sel u_pc_next_sel (
      .pc_plus4_i     (pc_plus4),
      .target26_i     (target26),
      .imm16_i        (imm16),
      .jr_target_i    (jr_target),
      .jump_i         (Jump),
      .jump_sel_i     (JumpSel),
      .branch_i       (Branch),
      .branch_taken_i (branch_taken),
      .next_pc_o      (next_pc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_RESET;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   // Memory responses are only accepted in FETCH/WAIT; redirects only in EXEC.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      case (state_q)
         S_RESET: state_d = S_FETCH;
         S_FETCH, S_WAIT: begin
            if (imem_valid) begin
               ir_d    = imem_rdata;
               state_d = S_ISSUE;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_ISSUE: begin
`ifdef FETCH_HALT_EN
            if (ir_q[31:26] == OP_RTYPE && ir_q[5:0] == FN_SYSCALL) begin
               state_d = S_HALT;
            end else begin
               state_d = S_EXEC;
            end
`else
            state_d = S_EXEC;
`endif
         end
         S_EXEC: begin
            pc_d    = next_pc;
            state_d = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_RESET;
      endcase
   end

   assign imem_req    = (state_q == S_FETCH);
   assign imem_addr   = pc_q;
   assign instr_valid = (state_q == S_ISSUE);
   assign pc_plus4    = pc_q + 32'd4;

   assign opcode   = ir_q[31:26];
   assign rs       = ir_q[25:21];
   assign rt       = ir_q[20:16];
   assign rd       = ir_q[15:11];
   assign funct    = ir_q[5:0];
   assign imm16    = ir_q[15:0];
   assign target26 = ir_q[25:0];

`ifdef FETCH_HALT_EN
   assign halted = (state_q == S_HALT);
`else
   assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized self-checking bench for instr_fetch against an instruction-level PC model.
module tb_instr_fetch;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_valid;
   logic [31:0] imem_rdata;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm16;
   logic [25:0] target26;
   logic [31:0] pc_plus4;
   logic        instr_valid;
   logic        Jump, Branch, JumpSel, branch_taken;
   logic [31:0] jr_target;
   logic        halted;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] mpc;

   instr_fetch dut (
      .clk          (clk),
      .reset        (reset),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_valid   (imem_valid),
      .imem_rdata   (imem_rdata),
      .opcode       (opcode),
      .funct        (funct),
      .rs           (rs),
      .rt           (rt),
      .rd           (rd),
      .imm16        (imm16),
      .target26     (target26),
      .pc_plus4     (pc_plus4),
      .instr_valid  (instr_valid),
      .Jump         (Jump),
      .Branch       (Branch),
      .JumpSel      (JumpSel),
      .branch_taken (branch_taken),
      .jr_target    (jr_target),
      .halted       (halted)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic noise_redirect();
      Jump         = 1'($urandom);
      Branch       = 1'($urandom);
      JumpSel      = 1'($urandom);
      branch_taken = 1'($urandom);
      jr_target    = $urandom;
   endtask

   function automatic logic is_syscall(input logic [31:0] w);
      return (w[31:26] == 6'h00) && (w[5:0] == 6'h0C);
   endfunction

   // Architectural next-PC rule, written as plain arithmetic on the instruction word.
   function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] w,
                                            input logic j, input logic b, input logic js,
                                            input logic bt, input logic [31:0] jr);
      logic [31:0] p4;
      int          off;
      p4  = pc + 32'd4;
      off = $signed(w[15:0]);
      if (j && js) return jr & 32'hFFFF_FFFC;
      if (j)       return (p4 & 32'hF000_0000) | (32'(w[25:0]) * 32'd4);
      if (b && bt) return p4 + 32'(off * 4);
      return p4;
   endfunction

   // Entered and left at the negedge of a FETCH cycle; cycle-exact, so period is checked too.
   task automatic run_instr(input logic [31:0] w, input int waits, input logic j, input logic b,
                            input logic js, input logic bt, input logic [31:0] jr);
      logic [68:0] exp_f;
      exp_f = {w[31:26], w[25:21], w[20:16], w[15:11], w[5:0], w[15:0], w[25:0]};
      noise_redirect();
      imem_valid = (waits == 0);
      imem_rdata = (waits == 0) ? w : $urandom;
      step();
      for (int i = 1; i <= waits; i++) begin
         total++;
         if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL wait_state req=%b iv=%b expected req=0 iv=0", imem_req, instr_valid);
         end
         imem_valid = (i == waits);
         imem_rdata = (i == waits) ? w : $urandom;
         step();
      end
      total++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
         bad++;
         $display("FAIL issue iv=%b req=%b expected iv=1 req=0", instr_valid, imem_req);
      end
      total++;
      if ({opcode, rs, rt, rd, funct, imm16, target26} !== exp_f) begin
         bad++;
         $display("FAIL fields got=%h expected=%h", {opcode, rs, rt, rd, funct, imm16, target26}, exp_f);
      end
      total++;
      if (pc_plus4 !== mpc + 32'd4) begin
         bad++;
         $display("FAIL pc_plus4 got=%h expected=%h", pc_plus4, mpc + 32'd4);
      end
      imem_valid = 1'($urandom);
      imem_rdata = $urandom;
      noise_redirect();
      step();
`ifdef FETCH_HALT_EN
      if (is_syscall(w)) begin
         for (int i = 0; i < 3; i++) begin
            total++;
            if (halted !== 1'b1 || imem_req !== 1'b0 || imem_addr !== mpc) begin
               bad++;
               $display("FAIL halt halted=%b req=%b addr=%h expected 1 0 %h", halted, imem_req, imem_addr, mpc);
            end
            imem_valid = 1'($urandom);
            step();
         end
         return;
      end
`endif
      total++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b0 || halted !== 1'b0) begin
         bad++;
         $display("FAIL exec iv=%b req=%b halted=%b expected 0 0 0", instr_valid, imem_req, halted);
      end
      Jump = j; Branch = b; JumpSel = js; branch_taken = bt; jr_target = jr;
      imem_valid = 1'($urandom);
      step();
      mpc = ref_next(mpc, w, j, b, js, bt, jr);
      noise_redirect();
      imem_valid = 1'b0;
      total++;
      if (imem_req !== 1'b1 || imem_addr !== mpc) begin
         bad++;
         $display("FAIL next_fetch req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, mpc);
      end
      total++;
      if (opcode !== w[31:26] || imm16 !== w[15:0]) begin
         bad++;
         $display("FAIL fields_hold op=%h imm=%h expected op=%h imm=%h", opcode, imm16, w[31:26], w[15:0]);
      end
   endtask

   task automatic bring_up_after_reset();
      reset      = 1'b0;
      imem_valid = 1'b0;
      for (int n = 0; n < 4 && imem_req !== 1'b1; n++) step();
      mpc = RESET_PC;
      total++;
      if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
         bad++;
         $display("FAIL reset_fetch req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RESET_PC);
      end
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      imem_valid = 1'($urandom);
      imem_rdata = $urandom;
      noise_redirect();
      step();
      step();
      total++;
      if ({imem_req, instr_valid, halted} !== 3'b000) begin
         bad++;
         $display("FAIL reset_ctrl req/iv/halted=%b expected 000", {imem_req, instr_valid, halted});
      end
      total++;
      if (imem_addr !== RESET_PC) begin
         bad++;
         $display("FAIL reset_pc got=%h expected=%h", imem_addr, RESET_PC);
      end
      total++;
      if ({opcode, rs, rt, rd, funct, imm16, target26} !== 69'd0) begin
         bad++;
         $display("FAIL reset_fields got=%h expected=0", {opcode, rs, rt, rd, funct, imm16, target26});
      end
      bring_up_after_reset();
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 2; i++) run_instr(32'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_syscall();
      run_instr(32'h0000_000C, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
`ifdef FETCH_HALT_EN
      test_reset();
`endif
   endtask

   task automatic test_redirects();
      run_instr({OP_J, 26'h000_0010}, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      run_instr({OP_J, 26'h000_0004}, 1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      run_instr({OP_BNE, 5'd1, 5'd2, 16'hFFFE}, 0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
      run_instr({OP_J, 26'h000_0004}, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      run_instr({OP_BNE, 5'd1, 5'd2, 16'hFFFE}, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      run_instr({OP_RTYPE, 5'd3, 15'd0, FN_JR}, 0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0123);
   endtask

   task automatic test_wrap();
      run_instr({OP_RTYPE, 5'd3, 15'd0, FN_JR}, 0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
      run_instr(32'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_reset_in_wait();
      run_instr(32'h2402_ABCD, 3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      imem_valid = 1'b0;
      step();
      total++;
      if (imem_req !== 1'b0) begin
         bad++;
         $display("FAIL wait_before_reset req=%b expected 0", imem_req);
      end
      step();
      reset = 1'b1;
      step();
      total++;
      if ({imem_req, instr_valid} !== 2'b00 || imem_addr !== RESET_PC ||
          {opcode, rs, rt, rd, funct, imm16, target26} !== 69'd0) begin
         bad++;
         $display("FAIL reset_in_wait req=%b iv=%b addr=%h op=%h imm=%h expected 0 0 %h 0 0",
                  imem_req, instr_valid, imem_addr, opcode, imm16, RESET_PC);
      end
      bring_up_after_reset();
   endtask

   task automatic test_random();
      logic [31:0] w;
      for (int k = 0; k < 40; k++) begin
         w = $urandom;
         if (is_syscall(w)) w[0] = 1'b1;
         run_instr(w, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), $urandom);
      end
   endtask

   initial begin
      reset = 1'b1; imem_valid = 1'b0; imem_rdata = '0;
      Jump = 1'b0; Branch = 1'b0; JumpSel = 1'b0; branch_taken = 1'b0; jr_target = '0;
      mpc = RESET_PC;
      @(negedge clk);
      test_reset();
      test_sequential();
      test_syscall();
      test_reset();
      test_redirects();
      test_wrap();
      test_reset_in_wait();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
